// File: rtl/hs_ram_arbiter.sv
// Shares the game work RAM between the CPU and the hiscore engine: pauses the CPU,
// waits for a quiet bus and a settle delay, then performs single-byte accesses.
module hs_ram_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int SETTLE   = 2,
  parameter int RD_LAT   = 1,
  parameter int HOLD_MAX = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_cs,
  input  logic          cpu_bus_idle,
  output logic [DW-1:0] cpu_rdata,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_ack,
  output logic          pause_req,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  // Handshake: hs_req is a level holding hs_we/hs_addr/hs_wdata stable until hs_ack
  // pulses for one cycle; on the following cycle the requester either drops hs_req
  // or presents the next request (burst while the CPU stays paused).

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE_WAIT, S_SETTLE, S_ACCESS, S_READ_WAIT, S_DONE, S_HOLD
  } state_t;

  localparam logic [3:0] SETTLE_C    = 4'(SETTLE);
  localparam logic [3:0] RD_LAT_C    = 4'(RD_LAT);
  localparam logic [7:0] HOLD_LAST_C = 8'(HOLD_MAX - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [7:0]    hold_cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          take_req;
  logic          cpu_owns;

  // The request is latched on the edge that enters ACCESS, from SETTLE or from HOLD.
  assign take_req = ((state == S_SETTLE) && (cnt == 4'd0)) ||
                    ((state == S_HOLD) && hs_req);

  assign cpu_owns  = (state == S_IDLE) || (state == S_PAUSE_WAIT);
  assign ram_addr  = cpu_owns ? cpu_addr : lat_addr;
  assign ram_wdata = cpu_owns ? cpu_wdata : lat_wdata;
  assign ram_we    = cpu_owns ? (cpu_we & cpu_cs) : ((state == S_ACCESS) && lat_we);
  assign cpu_rdata = ram_rdata;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (take_req) begin
      lat_we    <= hs_we;
      lat_addr  <= hs_addr;
      lat_wdata <= hs_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pause_req <= 1'b0;
      hs_ack    <= 1'b0;
      hs_rdata  <= '0;
      cnt       <= '0;
      hold_cnt  <= '0;
    end else begin
      hs_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs_req) begin
            state     <= S_PAUSE_WAIT;
            pause_req <= 1'b1;
          end
        end
        S_PAUSE_WAIT: begin
          if (!hs_req) begin
            state     <= S_IDLE;
            pause_req <= 1'b0;
          end else if (cpu_bus_idle) begin
            state <= S_SETTLE;
            cnt   <= SETTLE_C;
          end
        end
        S_SETTLE: begin
          if (cnt == 4'd0) state <= S_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        S_ACCESS: begin
          if (lat_we) begin
            state  <= S_DONE;
            hs_ack <= 1'b1;
          end else begin
            state <= S_READ_WAIT;
            cnt   <= RD_LAT_C;
          end
        end
        S_READ_WAIT: begin
          // Capture on the cycle the countdown reaches zero: RD_LAT cycles after ACCESS.
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            hs_rdata <= ram_rdata;
            state    <= S_DONE;
            hs_ack   <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_HOLD;
          hold_cnt <= '0;
        end
        S_HOLD: begin
          if (hs_req) begin
            state    <= S_ACCESS;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST_C) begin
            state     <= S_IDLE;
            pause_req <= 1'b0;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          pause_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game work RAM port between the CPU and the hiscore save/restore engine.
- Hiscore requests are serviced only while the CPU is held in pause.
- Handshake sequence: request pause, wait for a quiescent CPU bus, let the RAM settle, then grant single-byte accesses with a fixed-latency ack.
- Sits between the hiscore engine and the ladybug core RAM mux; its pause output is ORed with the user pause.

Parameters:
- AW, 16, RAM address width.
- DW, 8, RAM data width.
- SETTLE, 2, cycles held in pause before the first grant (1..15).
- RD_LAT, 1, synchronous RAM read latency in cycles (1..3).
- HOLD_MAX, 255, idle cycles with hs_req low before pause is released (1..255).

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  AW  CPU RAM address.
- cpu_wdata  in  DW  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_cs  in  1  CPU RAM chip select.
- cpu_bus_idle  in  1  high when the CPU is between bus cycles (no MREQ).
- cpu_rdata  out  DW  read data returned to the CPU.
- hs_req  in  1  hiscore access request (level).
- hs_we  in  1  hiscore write (1) / read (0); sampled with hs_req.
- hs_addr  in  AW  hiscore address; sampled with hs_req.
- hs_wdata  in  DW  hiscore write data; sampled with hs_req.
- hs_rdata  out  DW  hiscore read data; valid when hs_ack.
- hs_ack  out  1  one-cycle completion pulse.
- pause_req  out  1  CPU pause request.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DW  RAM read data.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; pause_req=0, hs_ack=0, ram_we=0, busy=0.
  - hs_rdata=0, settle counter=0, hold counter=0.
  - Reset mid-operation aborts any access; no ack is issued after reset.
- RAM mux:
  - In IDLE and PAUSE_WAIT the RAM port follows the CPU combinationally: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we&cpu_cs.
  - In every other state the RAM port is driven by latched hiscore values; ram_we=0 except in the ACCESS cycle of a write.
  - cpu_rdata=ram_rdata in all states.
- FSM:
  - IDLE: hs_req=1 -> PAUSE_WAIT, pause_req=1.
  - PAUSE_WAIT: cpu_bus_idle=1 -> SETTLE with counter=SETTLE. If hs_req drops first -> IDLE with pause_req=0.
  - SETTLE: counter decrements each cycle; at 0 -> ACCESS.
  - ACCESS: one cycle. Latch hs_we/hs_addr/hs_wdata at entry.
    - Write: ram_we=1 for exactly this cycle -> DONE.
    - Read: -> READ_WAIT with counter=RD_LAT.
  - READ_WAIT: decrement; at 0 capture ram_rdata into hs_rdata -> DONE.
  - DONE: hs_ack=1 for one cycle -> HOLD; hold counter=0.
  - HOLD: pause_req stays 1.
    - hs_req=1 -> ACCESS directly (no re-settle; burst mode).
    - hs_req=0 for HOLD_MAX consecutive cycles -> IDLE, pause_req=0 on the transition cycle.
    - Any hs_req high resets the hold counter.
- hs_req timing rules:
  - hs_req sampled in DONE is ignored.
  - The requester must drop hs_req or present the next request on the cycle after hs_ack.
- Latency: write ack is 1 cycle after ACCESS; read ack is RD_LAT+1 cycles after ACCESS.
- pause_req is never deasserted while an access is in flight (ACCESS, READ_WAIT, DONE).
- A CPU write strobe arriving in any non-IDLE/non-PAUSE_WAIT state is dropped. This is legal because the CPU is paused.

Test Plan:
- Reset release, no requests: all outputs 0. With cpu_addr=0x6000, cpu_cs=1, cpu_we=1, cpu_wdata=0x5A -> ram_we=1, ram_addr=0x6000 same cycle.
- Single write, SETTLE=2, cpu_bus_idle=1: hs_req with addr 0x6123, data 0xA5 at cycle 0.
  - pause_req=1 at cycle 1; SETTLE entered at cycle 2; ram_we=1 with 0x6123/0xA5 in cycle 5 only; hs_ack in cycle 6.
  - After 255 idle cycles, pause_req=0 and busy=0.
- Read with RD_LAT=2, RAM returning 0x3C: hs_ack arrives exactly 3 cycles after ACCESS with hs_rdata=0x3C; ram_we stays 0 throughout.
- Burst of 8 reads, hs_req re-asserted the cycle after each ack: only one PAUSE_WAIT/SETTLE sequence; pause_req stays high continuously; 8 acks with correct data.
- cpu_bus_idle held low for 50 cycles after hs_req: FSM remains in PAUSE_WAIT, RAM still follows the CPU. Dropping hs_req at cycle 30 -> IDLE next cycle, pause_req=0, no ack.
- reset_n pulsed low during READ_WAIT: outputs clear asynchronously; no hs_ack after release; next request completes normally.
